// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding and port IDs.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    localparam logic PortMem = 1'b0;
    localparam logic PortDbg = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the port other than last wins.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       id_o
);

    always_comb begin
        if (req_i == 2'b11) begin
            id_o = ~last_i;
        end else begin
            id_o = req_i[1] ? PortDbg : PortMem;
        end
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o = (id_o == PortDbg) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data_mem between the MEM stage (port 0) and the debug port (port 1),
// issuing one access at a time and routing registered read data back to the winner.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    state_e              state_q;
    logic                last_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                id_q;

    logic [1:0]          arb_gnt;
    logic                arb_id;
    logic                idle;
    logic                issue;
    logic                resp;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req_i  ({p1_req, p0_req}),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .id_o   (arb_id)
    );

    assign idle  = (state_q == StIdle);
    assign issue = (state_q == StIssue);
    assign resp  = (state_q == StResp);

    assign sel_we    = (arb_id == PortDbg) ? p1_we    : p0_we;
    assign sel_addr  = (arb_id == PortDbg) ? p1_addr  : p0_addr;
    assign sel_wdata = (arb_id == PortDbg) ? p1_wdata : p0_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|arb_gnt) begin
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        id_q    <= arb_id;
                        last_q  <= arb_id;
                        state_q <= StIssue;
                    end
                end
                StIssue: state_q <= we_q ? StIdle : StResp;
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Grants only in IDLE; everything else waits with its request held.
    assign p0_gnt = idle & arb_gnt[0];
    assign p1_gnt = idle & arb_gnt[1];

    // Pins are gated by the state register so an async reset drops the enables at once.
    assign mem_write_en    = issue & we_q;
    assign mem_read_en     = issue & ~we_q;
    assign mem_access_addr = issue ? addr_q  : '0;
    assign mem_write_data  = issue ? wdata_q : '0;

    assign p0_rvalid = resp & (id_q == PortMem);
    assign p1_rvalid = resp & (id_q == PortDbg);
    assign p0_rdata  = p0_rvalid ? mem_read_data : '0;
    assign p1_rdata  = p1_rvalid ? mem_read_data : '0;

    assign busy = ~idle;

endmodule
